la_iooutput_ctrl: RTL and testbench

- Core-side transmit controller for a gf180 bidirectional pad cell; the output-direction counterpart of the input pad wrapper.
- Accepts data bits from the core over a valid/ready handshake and drives the pad cell's A/OE/PU/PD/SL/drive pins.
- Sequences output-enable turn-on and turn-off with programmable settle and turnaround delays, and enforces a minimum hold time per driven bit.
- Sits between core logic and the pad cell instance in the IO ring.

---
 rtl/la_iooutput_ctrl.sv | 178 +++++++++++++++++
 tb/tb_la_iooutput_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/la_iooutput_ctrl.sv
// la_iooutput_ctrl: core-side transmit controller for a bidirectional pad cell.
// Takes one bit per valid/ready handshake from the core and drives the pad
// A/OE/PU/PD/SL/drive pins. OE turn-on is followed by an OEDLY-cycle settle,
// every accepted bit is held on pad_a for at least HOLD cycles, and OE stays
// up for TURN cycles after the last hold expires before it is released.
//
// Ports:
//   clk, nreset        clock, asynchronous active-low reset
//   en                 transmit enable (1 = drive the pad)
//   valid, data        core bit offer; transfer on valid & ready at posedge
//   ready              combinational: controller can take a bit this cycle
//   busy               controller is not idle
//   pe, ps             pull enable / pull select (1 = up), applied while idle
//   sl, drv            slew / drive strength, latched while idle
//   pad_a, pad_oe      pad cell data and output enable (registered)
//   pad_pu, pad_pd     pad cell pull-up / pull-down (registered)
//   pad_sl, pad_drv    pad cell slew and PDRV1:PDRV0 (registered)
module la_iooutput_ctrl #(
  parameter int unsigned OEDLY = 2,
  parameter int unsigned HOLD  = 1,
  parameter int unsigned TURN  = 1
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic       en,
  input  logic       valid,
  input  logic       data,
  output logic       ready,
  output logic       busy,
  input  logic       pe,
  input  logic       ps,
  input  logic       sl,
  input  logic [1:0] drv,
  output logic       pad_a,
  output logic       pad_oe,
  output logic       pad_pu,
  output logic       pad_pd,
  output logic       pad_sl,
  output logic [1:0] pad_drv
);

  localparam int unsigned CW = 8;
  localparam logic [CW-1:0] ONE      = CW'(1);
  localparam logic [CW-1:0] OEDLY_C  = CW'(OEDLY);
  localparam logic [CW-1:0] HOLD_C   = CW'(HOLD - 1);
  localparam logic [CW-1:0] TURN_C   = CW'(TURN);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ENABLE = 2'd1,
    ACTIVE = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   hold_q, hold_d;
  logic            a_q, a_d;
  logic            oe_q, oe_d;
  logic            pu_q, pu_d;
  logic            pd_q, pd_d;
  logic            sl_q, sl_d;
  logic [1:0]      drv_q, drv_d;
  logic            xfer;

  // Handshake: gated by en so no bit is taken in the cycle en drops.
  assign ready = (state_q == ACTIVE) && (hold_q == '0) && en;
  assign busy  = (state_q != IDLE);
  assign xfer  = valid && ready;

  assign pad_a   = a_q;
  assign pad_oe  = oe_q;
  assign pad_pu  = pu_q;
  assign pad_pd  = pd_q;
  assign pad_sl  = sl_q;
  assign pad_drv = drv_q;

  // State and pad registers; reset drops OE asynchronously.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hold_q  <= '0;
      a_q     <= 1'b0;
      oe_q    <= 1'b0;
      pu_q    <= 1'b0;
      pd_q    <= 1'b1;
      sl_q    <= 1'b0;
      drv_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      a_q     <= a_d;
      oe_q    <= oe_d;
      pu_q    <= pu_d;
      pd_q    <= pd_d;
      sl_q    <= sl_d;
      drv_q   <= drv_d;
    end
  end

  // Next-state and next pad values.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    // Hold counter runs down in every state and saturates at zero.
    hold_d  = (hold_q != '0) ? (hold_q - ONE) : hold_q;
    a_d     = a_q;
    oe_d    = oe_q;
    pu_d    = pu_q;
    pd_d    = pd_q;
    sl_d    = sl_q;
    drv_d   = drv_q;

    unique case (state_q)
      IDLE: begin
        oe_d  = 1'b0;
        pu_d  = pe & ps;
        pd_d  = pe & ~ps;
        sl_d  = sl;
        drv_d = drv;
        if (en) begin
          oe_d = 1'b1;
          pu_d = 1'b0;
          pd_d = 1'b0;
          if (OEDLY_C == '0) begin
            state_d = ACTIVE;
          end else begin
            state_d = ENABLE;
            cnt_d   = OEDLY_C;
          end
        end
      end

      ENABLE: begin
        oe_d = 1'b1;
        if (!en) begin
          state_d = DRAIN;
          cnt_d   = TURN_C;
        end else if (cnt_q <= ONE) begin
          state_d = ACTIVE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end

      ACTIVE: begin
        oe_d = 1'b1;
        if (xfer) begin
          a_d    = data;
          hold_d = HOLD_C;
        end
        if (!en) begin
          state_d = DRAIN;
          cnt_d   = TURN_C;
        end
      end

      DRAIN: begin
        oe_d = 1'b1;
        // Turnaround count only starts once the last bit's hold has expired.
        if (hold_q == '0) begin
          if (cnt_q == '0) begin
            state_d = IDLE;
            oe_d    = 1'b0;
          end else begin
            cnt_d = cnt_q - ONE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_la_iooutput_ctrl.sv
// Bench for la_iooutput_ctrl: two instances with different OEDLY/HOLD/TURN
// share one stimulus stream; a cycle-level model predicts every output.
module tb_la_iooutput_ctrl;

  logic       clk;
  logic       nreset;
  logic       en, valid, data, pe, ps, sl;
  logic [1:0] drv;

  logic       a_ready, a_busy, a_pad_a, a_pad_oe, a_pad_pu, a_pad_pd, a_pad_sl;
  logic [1:0] a_pad_drv;
  logic       b_ready, b_busy, b_pad_a, b_pad_oe, b_pad_pu, b_pad_pd, b_pad_sl;
  logic [1:0] b_pad_drv;

  int total = 0;
  int bad   = 0;

  localparam int OD [2] = '{2, 0};
  localparam int HD [2] = '{3, 1};
  localparam int TU [2] = '{2, 0};

  la_iooutput_ctrl #(.OEDLY(2), .HOLD(3), .TURN(2)) u_a (
    .clk(clk), .nreset(nreset), .en(en), .valid(valid), .data(data),
    .ready(a_ready), .busy(a_busy), .pe(pe), .ps(ps), .sl(sl), .drv(drv),
    .pad_a(a_pad_a), .pad_oe(a_pad_oe), .pad_pu(a_pad_pu), .pad_pd(a_pad_pd),
    .pad_sl(a_pad_sl), .pad_drv(a_pad_drv)
  );

  la_iooutput_ctrl #(.OEDLY(0), .HOLD(1), .TURN(0)) u_b (
    .clk(clk), .nreset(nreset), .en(en), .valid(valid), .data(data),
    .ready(b_ready), .busy(b_busy), .pe(pe), .ps(ps), .sl(sl), .drv(drv),
    .pad_a(b_pad_a), .pad_oe(b_pad_oe), .pad_pu(b_pad_pu), .pad_pd(b_pad_pd),
    .pad_sl(b_pad_sl), .pad_drv(b_pad_drv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [8:0] act, input logic [8:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%b want=%b", nm, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A session runs from the cycle en is sampled in idle (s0) until the pad is
  // released. OE is up from s0+1; bits are accepted from s0+1+OEDLY on, and a
  // bit taken in cycle t blocks the next until t+HOLD. If en is first seen low
  // in cycle s, OE is last high in cycle max(s+1, hold expiry) + TURN.
  int   cyc;
  bit   sess  [2];
  int   s0    [2];
  int   stopc [2];
  int   he    [2];
  logic m_a [2], m_oe [2], m_pu [2], m_pd [2], m_sl [2];
  logic [1:0] m_drv [2];

  function automatic int imax(input int x, input int y);
    return (x > y) ? x : y;
  endfunction

  function automatic logic exp_ready(input int k);
    return sess[k] && (stopc[k] < 0) && en && (cyc >= s0[k] + 1 + OD[k]) && (cyc >= he[k]);
  endfunction

  function automatic logic [8:0] exp_vec(input int k);
    return {exp_ready(k), sess[k], m_a[k], m_oe[k], m_pu[k], m_pd[k], m_sl[k], m_drv[k]};
  endfunction

  // Inputs change just after posedge, so mid-cycle they are the values the
  // next edge will sample: compare first, then advance the model one cycle.
  initial cyc = 0;
  always @(negedge clk) begin
    if (!nreset) begin
      for (int k = 0; k < 2; k++) begin
        sess[k] = 1'b0; s0[k] = 0; stopc[k] = -1; he[k] = 0;
        m_a[k] = 1'b0; m_oe[k] = 1'b0; m_pu[k] = 1'b0; m_pd[k] = 1'b1;
        m_sl[k] = 1'b0; m_drv[k] = 2'b00;
      end
    end else begin
      check("cmp_a", {a_ready, a_busy, a_pad_a, a_pad_oe, a_pad_pu, a_pad_pd, a_pad_sl, a_pad_drv}, exp_vec(0));
      check("cmp_b", {b_ready, b_busy, b_pad_a, b_pad_oe, b_pad_pu, b_pad_pd, b_pad_sl, b_pad_drv}, exp_vec(1));
      for (int k = 0; k < 2; k++) begin
        if (!sess[k]) begin
          m_sl[k]  = sl;
          m_drv[k] = drv;
          if (en) begin
            sess[k] = 1'b1; s0[k] = cyc; stopc[k] = -1;
            m_oe[k] = 1'b1; m_pu[k] = 1'b0; m_pd[k] = 1'b0;
          end else begin
            m_pu[k] = pe & ps;
            m_pd[k] = pe & ~ps;
          end
        end else begin
          if (exp_ready(k) && valid) begin
            m_a[k] = data;
            he[k]  = cyc + HD[k];
          end
          if (stopc[k] < 0 && !en) begin
            stopc[k] = cyc;
          end else if (stopc[k] >= 0 && cyc == imax(stopc[k] + 1, he[k]) + TU[k]) begin
            sess[k] = 1'b0;
            m_oe[k] = 1'b0;
          end
        end
      end
      cyc++;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  localparam logic [47:0] TEN = 48'h0000_FFF0_0FFE;
  localparam logic [47:0] TVA = 48'h0000_F5AC_6F7C;
  localparam logic [47:0] TDA = 48'h0000_3C96_A5A5;

  initial begin
    logic [47:0] ten, tva, tda;
    ten = TEN; tva = TVA; tda = TDA;

    nreset = 1'b1;
    en = 1'b0; valid = 1'b0; data = 1'b0;
    pe = 1'b1; ps = 1'b1; sl = 1'b1; drv = 2'b10;
    #2 nreset = 1'b0;
    #1;
    check("rst_pd", 9'(a_pad_pd), 9'd1);
    check("rst_pu", 9'(a_pad_pu), 9'd0);
    check("rst_oe", 9'(a_pad_oe), 9'd0);
    check("rst_drv", 9'(a_pad_drv), 9'd0);
    tick(); tick();
    nreset = 1'b1;
    tick();
    mid();
    check("rel_pu", 9'(a_pad_pu), 9'd1);
    check("rel_pd", 9'(a_pad_pd), 9'd0);
    check("rel_busy", 9'(a_busy), 9'd0);
    check("rel_sl_drv", {6'd0, a_pad_sl, a_pad_drv}, 9'b000000110);

    // cycle 0: enable
    tick(); en = 1'b1;
    mid(); check("c0_ready", 9'(a_ready), 9'd0);
    tick(); // c1
    mid(); check("c1_oe", 9'(a_pad_oe), 9'd1);
    check("c1_ready", 9'(a_ready), 9'd0);
    check("c1_b_ready", 9'(b_ready), 9'd1);
    tick(); // c2
    mid(); check("c2_ready", 9'(a_ready), 9'd0);
    tick(); valid = 1'b1; data = 1'b1; // c3
    mid(); check("c3_ready", 9'(a_ready), 9'd1);
    tick(); data = 1'b0; // c4
    mid(); check("c4_pad_a", 9'(a_pad_a), 9'd1);
    check("c4_ready", 9'(a_ready), 9'd0);
    check("c4_b_pad_a", 9'(b_pad_a), 9'd1);
    tick(); // c5
    mid(); check("c5_b_pad_a", 9'(b_pad_a), 9'd0);
    check("c5_ready", 9'(a_ready), 9'd0);
    tick(); // c6
    mid(); check("c6_ready", 9'(a_ready), 9'd1);
    check("c6_pad_a", 9'(a_pad_a), 9'd1);
    tick(); data = 1'b1; // c7
    mid(); check("c7_pad_a", 9'(a_pad_a), 9'd0);
    tick(); // c8
    mid(); check("c8_ready", 9'(a_ready), 9'd0);
    tick(); // c9
    mid(); check("c9_ready", 9'(a_ready), 9'd1);
    tick(); en = 1'b0; valid = 1'b0; // c10: drop en with two hold cycles left
    mid(); check("c10_pad_a", 9'(a_pad_a), 9'd1);
    check("c10_busy", 9'(a_busy), 9'd1);
    tick(); sl = 1'b0; drv = 2'b01; // c11
    tick(); en = 1'b1; // c12: pulse ignored while draining
    mid(); check("c12_ready", 9'(a_ready), 9'd0);
    check("c12_oe", 9'(a_pad_oe), 9'd1);
    tick(); en = 1'b0; // c13
    tick(); // c14
    mid(); check("c14_oe", 9'(a_pad_oe), 9'd1);
    check("c14_sl", 9'(a_pad_sl), 9'd1);
    tick(); // c15
    mid(); check("c15_oe", 9'(a_pad_oe), 9'd0);
    check("c15_busy", 9'(a_busy), 9'd0);
    check("c15_pu", 9'(a_pad_pu), 9'd0);
    tick(); // c16
    mid(); check("c16_pu", 9'(a_pad_pu), 9'd1);
    check("c16_sl_drv", {6'd0, a_pad_sl, a_pad_drv}, 9'b000000001);
    tick(); // c17
    tick(); en = 1'b1; // c18
    tick(); // c19
    mid(); check("c19_oe", 9'(a_pad_oe), 9'd1);
    check("c19_pad_a", 9'(a_pad_a), 9'd1);
    check("c19_ready", 9'(a_ready), 9'd0);
    tick(); // c20
    tick(); valid = 1'b1; data = 1'b0; // c21
    mid(); check("c21_ready", 9'(a_ready), 9'd1);
    tick(); valid = 1'b0; // c22: reset between edges while holding
    #2 nreset = 1'b0;
    #1;
    check("arst_oe", 9'(a_pad_oe), 9'd0);
    check("arst_pd", 9'(a_pad_pd), 9'd1);
    check("arst_b_oe", 9'(b_pad_oe), 9'd0);
    en = 1'b0;
    tick(); tick();
    nreset = 1'b1;
    mid();
    check("post_pad_a", 9'(a_pad_a), 9'd0);
    check("post_busy", 9'(a_busy), 9'd0);
    ps = 1'b0;
    tick();
    mid(); check("post_pd", 9'(a_pad_pd), 9'd1);

    // table-driven traffic, checked only by the model
    for (int i = 0; i < 48; i++) begin
      tick();
      en    = ten[i];
      valid = tva[i];
      data  = tda[i];
      ps    = tda[(i + 5) % 48];
    end
    en = 1'b0; valid = 1'b0;
    repeat (12) tick();
    mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
